down_counter_load: RTL and testbench
====================================

// Module: down_counter_load
//
// PURPOSE
//   Synchronous W-bit down counter with parallel load, count enable, programmable
//   wrap value, and terminal-count (borrow) output. It is the count-down companion of
//   the team's up-counter. Intended uses: timeout and delay generation, and cascading
//   through tc into a higher-order stage.
//   Built from JK flip-flop cells that share one clock edge, like the existing
//   structural counters.
//
// PARAMETERS
//   WIDTH     3               counter width in bits (>=1)
//   WRAP_VAL  (1<<WIDTH)-1    value loaded on underflow (q==0 with en=1); must be < 2**WIDTH
//
// PORTS
//   clk     in   1      rising-edge clock, shared by all flip-flops
//   clrbar  in   1      asynchronous active-low clear; 0 forces q=0 immediately
//   load    in   1      synchronous parallel load; has priority over en
//   en      in   1      synchronous count-down enable
//   d       in   WIDTH  parallel load data
//   q       out  WIDTH  counter state
//   qbar    out  WIDTH  bitwise complement of q, always ~q
//   zero    out  1      combinational: q == 0
//   tc      out  1      combinational borrow: en & ~load & (q == 0)
//
// BEHAVIOUR
//   - Reset: clrbar=0 asynchronously forces q=0, qbar={WIDTH{1}}, zero=1, tc=en&~load.
//     Clear overrides clk, load and en.
//   - Reset release: clrbar 0->1 has no effect by itself. The first rising clk edge
//     with clrbar=1 is evaluated normally.
//   - Each rising clk edge with clrbar=1, in priority order:
//       load=1              -> q <= d (en is ignored)
//       load=0, en=1, q!=0  -> q <= q - 1 (modulo 2**WIDTH; never reached for q=0)
//       load=0, en=1, q==0  -> q <= WRAP_VAL (underflow; tc is high during this cycle)
//       load=0, en=0        -> q holds
//   - Latency: one clock from load/en to the q update. zero and tc have zero latency
//     relative to q, en and load.
//   - A loaded value greater than WRAP_VAL is legal. It counts down normally to 0 and
//     then wraps to WRAP_VAL.
//   - Loading d=0 gives zero=1 on the next cycle. tc then follows en.
//   - Cascading: the tc of a lower stage drives the en of the next stage. The combined
//     count is correct only when every stage uses WRAP_VAL = 2**WIDTH-1.
//   - Clear asserted mid-count: q goes to 0 with no clock edge required. No partial
//     update may occur on an edge coincident with clrbar=0.
//   - No X on any output after clear, including when d is X and load=0.
//
// STRUCTURE
//   - Sub-module jk_ff_cell (J, K, clk, clrbar, Q, Qbar): rising-edge JK flip-flop with
//     async active-low clear. One instance per bit, generated over WIDTH.
//   - Per-bit next value n[i]:
//       load       -> d[i]
//       underflow  -> WRAP_VAL[i]
//       count      -> q[i] toggles when all lower bits are 0 (borrow chain: b0=1, b[i+1]=b[i]&qbar[i])
//       hold       -> q[i]
//   - Per-bit JK inputs: J=n[i]&qbar[i], K=~n[i]&q[i].
//   - Borrow chain, underflow detect, and mux are gate-level or continuous assigns.
//     All state lives in jk_ff_cell.
//   - Shared header counter_defs.vh: default WIDTH, a macro for the all-ones wrap
//     value, and a function for the WRAP_VAL range check used by the elaboration-time
//     assertion.
//
// TESTING
//   - Default params: clrbar=0 then 1, en=1 for 9 cycles -> q = 0,7,6,5,4,3,2,1,0,7.
//     tc=1 exactly in the cycles where q==0.
//   - load=1, d=5, en=1 for one edge -> q=5 (no decrement). Then en=0 for 3 edges -> q stays 5.
//   - q=3 mid-count: drop clrbar between clock edges -> q=0 and qbar=7 at once, before
//     the next edge. Hold clrbar=0 across 2 edges with en=1 -> q stays 0.
//   - WIDTH=3, WRAP_VAL=5: load 7, en=1 -> q = 7,6,5,4,3,2,1,0,5,4. tc high only at q=0.
//   - Two cascaded default instances (low.tc -> high.en): 70 enabled cycles from 0 ->
//     {high,low} = 64-70 mod 64 = 58 (high=7, low=2). high.tc never fires before low.tc.
//   - Load with en=0 at q=0: tc=0. Raise en -> tc=1 combinationally. Next edge -> q=WRAP_VAL.

Source files
------------

// File: rtl/down_counter_load_pkg.sv
// Shared definitions for the down counter: default width, the all-ones wrap value,
// the WRAP_VAL range check and the JK cell operation encoding.
package down_counter_load_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32'd3;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    function automatic int unsigned all_ones(input int unsigned width);
        return int'((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic wrap_val_ok(input int unsigned width, input int unsigned wrap);
        return (64'(wrap) < (64'd1 << width));
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Rising-edge JK flip-flop with asynchronous active-low clear; one per counter bit.
module jk_ff_cell
    import down_counter_load_pkg::*;
(
    input  logic clk,
    input  logic clrbar,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_r;

    // JK state update; clear overrides the clock edge
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            q_r <= 1'b0;
        end else begin
            case (jk_op_e'({j, k}))
                JK_HOLD:   q_r <= q_r;
                JK_RESET:  q_r <= 1'b0;
                JK_SET:    q_r <= 1'b1;
                JK_TOGGLE: q_r <= ~q_r;
                default:   q_r <= q_r;
            endcase
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;

endmodule

// File: rtl/down_counter_load.sv
// W-bit down counter with parallel load, count enable, programmable wrap value and
// combinational borrow output, built from one JK cell per bit.
module down_counter_load
    import down_counter_load_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned WRAP_VAL = all_ones(WIDTH)
) (
    input  logic             clk,
    input  logic             clrbar,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             zero,
    output logic             tc
);

    localparam logic [WIDTH-1:0] WRAP_BITS = WIDTH'(WRAP_VAL);

    if (WIDTH < 32'd1) begin : g_bad_width
        $error("down_counter_load: WIDTH must be at least 1");
    end
    if (!wrap_val_ok(WIDTH, WRAP_VAL)) begin : g_bad_wrap
        $error("down_counter_load: WRAP_VAL must be below 2**WIDTH");
    end

    logic [WIDTH-1:0] borrow_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             underflow_s;

    assign zero        = (q == {WIDTH{1'b0}});
    assign underflow_s = en & ~load & zero;
    assign tc          = underflow_s;

    assign borrow_s[0] = 1'b1;

    genvar i;
    generate
        // A bit borrows (toggles on decrement) only when every lower bit is zero
        for (i = 1; i < WIDTH; i++) begin : g_borrow
            assign borrow_s[i] = &qbar[i-1:0];
        end

        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign next_s[i] = load        ? d[i] :
                               underflow_s ? WRAP_BITS[i] :
                               en          ? (q[i] ^ borrow_s[i]) :
                                             q[i];
            assign j_s[i] = next_s[i] & qbar[i];
            assign k_s[i] = ~next_s[i] & q[i];

            jk_ff_cell u_cell (
                .clk    (clk),
                .clrbar (clrbar),
                .j      (j_s[i]),
                .k      (k_s[i]),
                .q      (q[i]),
                .qbar   (qbar[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_down_counter_load.sv
// Directed bench for down_counter_load: default instance, a WRAP_VAL=5 instance and
// a two-stage cascade, all checked against hand-computed values.
module tb_down_counter_load;

    logic clk;
    int   n_vec;
    int   n_err;

    // default-parameter instance
    logic       a_clrbar, a_load, a_en;
    logic [2:0] a_d, a_q, a_qbar;
    logic       a_zero, a_tc;

    // WRAP_VAL = 5 instance
    logic       w_clrbar, w_load, w_en;
    logic [2:0] w_d, w_q, w_qbar;
    logic       w_zero, w_tc;

    // cascade: lo.tc drives hi.en
    logic       c_clrbar, c_en;
    logic [2:0] lo_q, lo_qbar, hi_q, hi_qbar;
    logic       lo_zero, lo_tc, hi_zero, hi_tc;

    down_counter_load dut (
        .clk(clk), .clrbar(a_clrbar), .load(a_load), .en(a_en), .d(a_d),
        .q(a_q), .qbar(a_qbar), .zero(a_zero), .tc(a_tc)
    );

    down_counter_load #(.WIDTH(3), .WRAP_VAL(5)) dut_w5 (
        .clk(clk), .clrbar(w_clrbar), .load(w_load), .en(w_en), .d(w_d),
        .q(w_q), .qbar(w_qbar), .zero(w_zero), .tc(w_tc)
    );

    down_counter_load dut_lo (
        .clk(clk), .clrbar(c_clrbar), .load(1'b0), .en(c_en), .d(3'd0),
        .q(lo_q), .qbar(lo_qbar), .zero(lo_zero), .tc(lo_tc)
    );

    down_counter_load dut_hi (
        .clk(clk), .clrbar(c_clrbar), .load(1'b0), .en(lo_tc), .d(3'd0),
        .q(hi_q), .qbar(hi_qbar), .zero(hi_zero), .tc(hi_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2:0] seq_a [9];
        logic [2:0] seq_w [9];
        n_vec = 0;
        n_err = 0;
        seq_a = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        seq_w = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4};

        a_clrbar = 1'b0; a_load = 1'b0; a_en = 1'b0; a_d = 3'd0;
        w_clrbar = 1'b0; w_load = 1'b0; w_en = 1'b0; w_d = 3'd0;
        c_clrbar = 1'b0; c_en = 1'b0;

        // reset state
        #3;
        check("rst_q", 32'(a_q), 32'd0);
        check("rst_qbar", 32'(a_qbar), 32'd7);
        check("rst_zero", 32'(a_zero), 32'd1);
        check("rst_tc_en0", 32'(a_tc), 32'd0);
        a_en = 1'b1;
        #1;
        check("rst_tc_en1", 32'(a_tc), 32'd1);
        a_clrbar = 1'b1;
        w_clrbar = 1'b1;
        c_clrbar = 1'b1;
        #0;
        check("release_q", 32'(a_q), 32'd0);

        // free-running count with wrap to 7
        for (int i = 0; i < 9; i++) begin
            step();
            check("count_q", 32'(a_q), 32'(seq_a[i]));
            check("count_tc", 32'(a_tc), (seq_a[i] == 3'd0) ? 32'd1 : 32'd0);
        end

        // load has priority over en, then hold
        a_load = 1'b1; a_d = 3'd5; a_en = 1'b1;
        step();
        check("load5_q", 32'(a_q), 32'd5);
        a_load = 1'b0; a_en = 1'b0; a_d = 3'bxxx;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_q", 32'(a_q), 32'd5);
        end
        check("hold_zero", 32'(a_zero), 32'd0);

        // async clear mid-count
        a_load = 1'b1; a_d = 3'd4;
        step();
        a_load = 1'b0; a_en = 1'b1;
        step();
        check("pre_clr_q", 32'(a_q), 32'd3);
        #2;
        a_clrbar = 1'b0;
        #1;
        check("clr_async_q", 32'(a_q), 32'd0);
        check("clr_async_qbar", 32'(a_qbar), 32'd7);
        for (int i = 0; i < 2; i++) begin
            step();
            check("clr_held_q", 32'(a_q), 32'd0);
        end
        a_en = 1'b0;
        a_clrbar = 1'b1;
        step();
        check("post_clr_q", 32'(a_q), 32'd0);

        // load 0 with en=0, then raise en
        a_load = 1'b1; a_d = 3'd0; a_en = 1'b0;
        #1;
        check("load0_tc", 32'(a_tc), 32'd0);
        step();
        a_load = 1'b0;
        #1;
        check("load0_zero", 32'(a_zero), 32'd1);
        check("load0_tc_en0", 32'(a_tc), 32'd0);
        a_en = 1'b1;
        #1;
        check("load0_tc_en1", 32'(a_tc), 32'd1);
        step();
        check("load0_wrap_q", 32'(a_q), 32'd7);
        a_en = 1'b0;

        // WRAP_VAL=5 instance loaded above its wrap value
        w_load = 1'b1; w_d = 3'd7; w_en = 1'b1;
        step();
        check("w5_load_q", 32'(w_q), 32'd7);
        w_load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check("w5_q", 32'(w_q), 32'(seq_w[i]));
            check("w5_tc", 32'(w_tc), (seq_w[i] == 3'd0) ? 32'd1 : 32'd0);
        end
        w_en = 1'b0;

        // two-stage cascade counting down from 0
        c_en = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step();
            check("casc_val", 32'({hi_q, lo_q}), 32'((64 - (k % 64)) % 64));
            check("casc_order", 32'(hi_tc & ~lo_tc), 32'd0);
        end
        check("casc_hi", 32'(hi_q), 32'd7);
        check("casc_lo", 32'(lo_q), 32'd2);
        c_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
